// File: rtl/seq_sched_pkg.sv
// rtl/seq_sched_pkg.sv - shared FSM state type and default sizing for seq_detect_sched
package seq_sched_pkg;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_RESP} sched_state_t;

   localparam int SCHED_N     = 4;
   localparam int SCHED_W     = 8;
   localparam int SCHED_ID_W  = $clog2(SCHED_N);
   localparam int SCHED_CNT_W = $clog2(SCHED_W + 1);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr, wrapping
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] index
);

   localparam int IW = $clog2(N);

   logic found;

   always_comb begin
      gnt   = '0;
      index = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found                       = 1'b1;
            gnt[(int'(ptr) + k) % N]    = 1'b1;
            index                       = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one serial sequence detector among N requesters
// Optional resp_first output under SCHED_FIRSTHIT_EN.
module seq_detect_sched
   import seq_sched_pkg::*;
#(
   parameter int N = SCHED_N,
   parameter int W = SCHED_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N-1:0]           req_valid,
   input  logic [N*W-1:0]         req_data,
   output logic [N-1:0]           req_ready,
   output logic                   det_reset,
   output logic                   det_in,
   input  logic                   det_out,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [$clog2(N)-1:0]   resp_id,
   output logic [$clog2(W+1)-1:0] resp_count,
   output logic                   busy
`ifdef SCHED_FIRSTHIT_EN
   ,
   output logic [$clog2(W):0]     resp_first
`endif
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(W + 1);
   localparam int BW = $clog2(W);
`ifdef SCHED_FIRSTHIT_EN
   localparam int FW = $clog2(W) + 1;
`endif

   sched_state_t  state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] id_q, id_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] count_q, count_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
`ifdef SCHED_FIRSTHIT_EN
   logic [FW-1:0] first_q, first_d;
`endif

   logic [N-1:0]  gnt;
   logic [IW-1:0] gidx;

   rr_arbiter #(.N(N)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .gnt   (gnt),
      .index (gidx)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      shreg_d   = shreg_q;
      count_d   = count_q;
      bit_cnt_d = bit_cnt_q;
`ifdef SCHED_FIRSTHIT_EN
      first_d   = first_q;
`endif
      req_ready = '0;
      det_in    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               // Gated by reset so a word is never consumed by a cycle that is being discarded.
               req_ready = reset ? '0 : gnt;
               shreg_d   = req_data[int'(gidx)*W +: W];
               id_d      = gidx;
               rr_ptr_d  = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
               count_d   = '0;
`ifdef SCHED_FIRSTHIT_EN
               first_d   = '1;
`endif
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            det_in    = shreg_q[W-1];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            // det_out lags det_in by one cycle, so it reports bit (bit_cnt - 1).
            if (bit_cnt_q != '0) begin
               count_d = count_q + CW'(det_out);
`ifdef SCHED_FIRSTHIT_EN
               if (det_out && (first_q == '1)) first_d = FW'(bit_cnt_q) - 1'b1;
`endif
            end
            if (bit_cnt_q == BW'(W - 1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            count_d = count_q + CW'(det_out);
`ifdef SCHED_FIRSTHIT_EN
            if (det_out && (first_q == '1)) first_d = FW'(W - 1);
`endif
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         shreg_q   <= '0;
         count_q   <= '0;
         bit_cnt_q <= '0;
`ifdef SCHED_FIRSTHIT_EN
         first_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         shreg_q   <= shreg_d;
         count_q   <= count_d;
         bit_cnt_q <= bit_cnt_d;
`ifdef SCHED_FIRSTHIT_EN
         first_q   <= first_d;
`endif
      end
   end

   assign det_reset  = reset | (state_q == S_CLEAR);
   assign resp_valid = (state_q == S_RESP);
   assign resp_id    = id_q;
   assign resp_count = count_q;
   assign busy       = (state_q != S_IDLE);
`ifdef SCHED_FIRSTHIT_EN
   assign resp_first = first_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - scoreboard bench for seq_detect_sched with a registered stub detector
module tb_seq_detect_sched;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int FW = $clog2(W) + 1;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           det_reset, det_in;
   logic           det_out = 1'b0;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [1:0]     resp_id;
   logic [3:0]     resp_count;
   logic           busy;
`ifdef SCHED_FIRSTHIT_EN
   logic [FW-1:0]  resp_first;
`endif

   seq_detect_sched #(.N(N), .W(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .det_reset  (det_reset),
      .det_in     (det_in),
      .det_out    (det_out),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_count (resp_count),
      .busy       (busy)
`ifdef SCHED_FIRSTHIT_EN
      ,
      .resp_first (resp_first)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) det_out <= det_reset ? 1'b0 : det_in;

   int cyc = 0;
   always @(posedge clock) cyc++;

   typedef struct { int id; int cnt; int first; int t_acc; } exp_t;
   typedef struct { int r; logic [W-1:0] w; } job_t;

   exp_t       exp_q[$];
   job_t       pend_q[$];
   int         grants[$];
   int         checks = 0;
   int         fails = 0;
   int         ptr_m = 0;
   bit         busy_m = 0;
   int         t_acc_m = -100;
   logic [W-1:0] cur_word = '0;
   int         acc_pend = -1;
   int         n_acc = 0;
   int         last_acc = 0;
   bit         resp_seen = 0;
   int         rdy_mode = 0;
   int         last_id = -1, last_cnt = -1, last_first = -1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int popcount(input logic [W-1:0] w);
      int c = 0;
      for (int b = 0; b < W; b++) c += int'(w[b]);
      return c;
   endfunction

   function automatic int first_hit(input logic [W-1:0] w);
      for (int b = 0; b < W; b++) if (w[W-1-b]) return b;
      return (1 << FW) - 1;
   endfunction

   task automatic sample();
      int g;
      exp_t e;
      if (reset) begin
         check("det_reset_during_reset", det_reset, 1);
         check("req_ready_during_reset", req_ready, 0);
         exp_q.delete();
         busy_m = 0; ptr_m = 0; t_acc_m = -100; resp_seen = 0;
         return;
      end
      g = -1;
      if (!busy_m)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      check("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      check("busy", busy, busy_m);
      check("det_reset", det_reset, (cyc == t_acc_m + 1) ? 1 : 0);
      if (cyc >= t_acc_m + 2 && cyc <= t_acc_m + W + 1)
         check("det_in_shift", det_in, int'(cur_word[W - 1 - (cyc - t_acc_m - 2)]));
      else
         check("det_in_idle", det_in, 0);
      if (g >= 0) begin
         cur_word = req_data[g*W +: W];
         exp_q.push_back('{id: g, cnt: popcount(cur_word), first: first_hit(cur_word), t_acc: cyc});
         grants.push_back(g);
         ptr_m = (g + 1) % N; busy_m = 1; t_acc_m = cyc;
         acc_pend = g; n_acc++; last_acc = cyc;
      end
      if (resp_valid) begin
         if (exp_q.size() == 0) check("resp_valid_unexpected", resp_valid, 0);
         else begin
            e = exp_q[0];
            if (!resp_seen) begin
               check("resp_latency", cyc - e.t_acc, W + 3);
               resp_seen = 1;
            end
            check("resp_id", resp_id, e.id);
            check("resp_count", resp_count, e.cnt);
`ifdef SCHED_FIRSTHIT_EN
            check("resp_first", resp_first, e.first);
`endif
            if (resp_ready) begin
               last_id = resp_id; last_cnt = resp_count;
`ifdef SCHED_FIRSTHIT_EN
               last_first = resp_first;
`endif
               void'(exp_q.pop_front());
               resp_seen = 0; busy_m = 0;
            end
         end
      end else if (exp_q.size() > 0 && cyc == exp_q[0].t_acc + W + 3) begin
         check("resp_valid_due", resp_valid, 1);
      end
   endtask

   // Requester and consumer behaviour, then the scoreboard sample just before the next posedge.
   always begin
      @(negedge clock);
      if (acc_pend >= 0) begin
         req_valid[acc_pend] = 1'b0;
         acc_pend = -1;
      end
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i]) begin
            for (int k = 0; k < pend_q.size(); k++) begin
               if (pend_q[k].r == i) begin
                  req_data[i*W +: W] = pend_q[k].w;
                  req_valid[i] = 1'b1;
                  pend_q.delete(k);
                  break;
               end
            end
         end
      end
      case (rdy_mode)
         0:       resp_ready = 1'b1;
         1:       resp_ready = ($urandom_range(0, 3) != 0);
         default: resp_ready = 1'b0;
      endcase
      #4;
      sample();
   end

   task automatic push(input int r, input logic [W-1:0] w);
      pend_q.push_back('{r: r, w: w});
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock); #3;
         if (pend_q.size() == 0 && req_valid == '0 && exp_q.size() == 0 && !busy_m) return;
      end
      check("drain_timeout", pend_q.size() + exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #3;
   endtask

   initial begin
      int t0, n0;
      logic [3:0] cnt_hold;
      logic [1:0] id_hold;
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_count", resp_count, 0);
      check("rst_det_in", det_in, 0);
      check("rst_req_ready", req_ready, 0);

      push(1, 8'hB6);
      wait_drain();
      check("t1_id", last_id, 1);
      check("t1_count", last_cnt, 5);

      do_reset();
      grants.delete();
      push(0, 8'hFF); push(1, 8'hFF); push(2, 8'hFF); push(3, 8'hFF); push(0, 8'hFF);
      wait_drain();
      check("t2_ngrants", grants.size(), 5);
      if (grants.size() == 5) begin
         check("t2_g0", grants[0], 0); check("t2_g1", grants[1], 1);
         check("t2_g2", grants[2], 2); check("t2_g3", grants[3], 3);
         check("t2_g4", grants[4], 0);
      end
      check("t2_count", last_cnt, 8);

      push(2, 8'h00); wait_drain(); check("t3_zero", last_cnt, 0);
      push(3, 8'h80); wait_drain(); check("t3_msb", last_cnt, 1);

      rdy_mode = 2;
      push(0, 8'h5A); push(1, 8'h3C);
      for (int k = 0; k < 100 && !resp_valid; k++) begin @(negedge clock); #3; end
      check("t4_resp_valid", resp_valid, 1);
      id_hold = resp_id; cnt_hold = resp_count;
      repeat (5) begin
         @(negedge clock); #3;
         check("t4_hold_valid", resp_valid, 1);
         check("t4_hold_id", resp_id, int'(id_hold));
         check("t4_hold_count", resp_count, int'(cnt_hold));
         check("t4_hold_ready", req_ready, 0);
      end
      rdy_mode = 0;
      wait_drain();

      n0 = n_acc;
      push(2, 8'hF0);
      for (int k = 0; k < 100 && n_acc == n0; k++) begin @(negedge clock); #3; end
      check("t5_accept", n_acc - n0, 1);
      t0 = last_acc;
      while (cyc < t0 + 5) @(negedge clock);
      reset = 1'b1;
      #3;
      check("t5_det_reset", det_reset, 1);
      @(negedge clock); reset = 1'b0;
      #3;
      check("t5_busy", busy, 0);
      check("t5_resp_valid", resp_valid, 0);
      push(2, 8'h6E); wait_drain(); check("t5_next_count", last_cnt, 5);

      rdy_mode = 1;
      for (int j = 0; j < 40; j++) begin
         push($urandom_range(0, N - 1), W'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clock);
      end
      wait_drain();
      rdy_mode = 0;

`ifdef SCHED_FIRSTHIT_EN
      push(1, 8'h20); wait_drain(); check("t6_first_20", last_first, 2);
      push(1, 8'h00); wait_drain(); check("t6_first_none", last_first, (1 << FW) - 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
